// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the hash-result scanner: FSM states, defaults,
// and the bit layout of the second summary word.
package bitcoin_pkg;

  localparam int NUM_NONCES_DFLT = 16;
  localparam int SUMMARY_WORDS   = 2;
  localparam int FOUND_BIT       = 31;
  localparam int COUNT_LSB       = 16;
  localparam int NONCE_LSB       = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WR_HASH,
    S_WR_SUM,
    S_DONE
  } scan_state_e;

  function automatic logic [31:0] make_summary(input logic [7:0] count,
                                               input logic [7:0] nonce);
    logic [31:0] w;
    w = '0;
    w[FOUND_BIT]      = (count != 8'd0);
    w[COUNT_LSB +: 8] = count;
    w[NONCE_LSB +: 8] = nonce;
    return w;
  endfunction

endpackage

// File: rtl/hash_result_scanner_if.sv
// Single-port synchronous memory bus shared with the hasher; the scanner is
// the master, the memory (or top-level mux) the slave.
interface hash_result_scanner_if #(
  parameter int ADDR_W = 16
);
  logic              mem_clk;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  modport master (
    output mem_clk, mem_we, mem_addr, mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_clk, mem_we, mem_addr, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/hash_result_scanner_min.sv
// scan_min_tracker: running minimum digest, its index, and target-match tally.
// One compare per valid word; next-state values exported so a writer can use the final compare.
module scan_min_tracker #(
  parameter int NUM_NONCES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_vld,
  input  logic [7:0]            i_idx,
  input  logic [31:0]           i_word,
  input  logic [31:0]           i_target,
  output logic [31:0]           o_best_hash,
  output logic [31:0]           o_best_hash_nxt,
  output logic [7:0]            o_best_nonce,
  output logic [7:0]            o_match_count,
  output logic [NUM_NONCES-1:0] o_match_mask
);

  logic [31:0]           r_best_hash;
  logic [7:0]            r_best_nonce;
  logic [7:0]            r_match_count;
  logic [NUM_NONCES-1:0] r_match_mask;

  logic [31:0]           w_hash_nxt;
  logic [7:0]            w_nonce_nxt;
  logic [7:0]            w_count_nxt;
  logic [NUM_NONCES-1:0] w_mask_nxt;

  always_comb begin
    w_hash_nxt  = r_best_hash;
    w_nonce_nxt = r_best_nonce;
    w_count_nxt = r_match_count;
    w_mask_nxt  = r_match_mask;
    if (i_vld) begin
      // Strict compare keeps the lowest index on ties.
      if (i_word < r_best_hash) begin
        w_hash_nxt  = i_word;
        w_nonce_nxt = i_idx;
      end
      if (i_word < i_target) begin
        w_count_nxt = r_match_count + 8'd1;
        w_mask_nxt  = r_match_mask | (NUM_NONCES'(1) << i_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_best_hash   <= 32'hFFFF_FFFF;
      r_best_nonce  <= 8'd0;
      r_match_count <= 8'd0;
      r_match_mask  <= '0;
    end else begin
      r_best_hash   <= w_hash_nxt;
      r_best_nonce  <= w_nonce_nxt;
      r_match_count <= w_count_nxt;
      r_match_mask  <= w_mask_nxt;
    end
  end

  assign o_best_hash     = r_best_hash;
  assign o_best_hash_nxt = w_hash_nxt;
  assign o_best_nonce    = r_best_nonce;
  assign o_match_count   = r_match_count;
  assign o_match_mask    = r_match_mask;

endmodule

// File: rtl/hash_result_scanner.sv
// Scans NUM_NONCES digest words, tracks min/matches, writes a 2-word summary, raises done.
// done first visible NUM_NONCES+4 cycles after the accepted start edge.
module hash_result_scanner
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = NUM_NONCES_DFLT,
  parameter int ADDR_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     output_addr,
  input  logic [ADDR_W-1:0]     report_addr,
  input  logic [31:0]           target,
  output logic                  done,
  hash_result_scanner_if.master mem,
  output logic [31:0]           best_hash,
  output logic [7:0]            best_nonce,
  output logic [7:0]            match_count,
  output logic [NUM_NONCES-1:0] match_mask
);

  localparam logic [7:0] LAST_CNT = 8'(NUM_NONCES);

  scan_state_e       r_state;
  scan_state_e       w_state_nxt;
  logic              w_accept;

  logic [ADDR_W-1:0] r_report_addr;
  logic [31:0]       r_target;
  logic [7:0]        r_cnt;
  logic              r_vld;
  logic [7:0]        r_idx;
  logic              r_done;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       w_best_hash_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ:    if (r_cnt == LAST_CNT) w_state_nxt = S_DRAIN;
      S_DRAIN:   w_state_nxt = S_WR_HASH;
      S_WR_HASH: w_state_nxt = S_WR_SUM;
      S_WR_SUM:  w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // r_cnt holds the 1-based number of the address currently on the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_report_addr <= '0;
      r_target      <= '0;
      r_cnt         <= 8'd0;
      r_vld         <= 1'b0;
      r_idx         <= 8'd0;
      r_done        <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
    end else begin
      r_mem_we <= (w_state_nxt == S_WR_HASH) || (w_state_nxt == S_WR_SUM);
      r_vld    <= (r_state == S_READ);
      r_idx    <= r_cnt - 8'd1;
      if (w_accept) begin
        r_report_addr <= report_addr;
        r_target      <= target;
        r_mem_addr    <= output_addr;
        r_cnt         <= 8'd1;
        r_done        <= 1'b0;
      end else if (r_state == S_READ && w_state_nxt == S_READ) begin
        r_mem_addr <= r_mem_addr + ADDR_W'(1);
        r_cnt      <= r_cnt + 8'd1;
      end
      // The hash word must reflect the compare finishing on this same edge.
      if (w_state_nxt == S_WR_HASH) begin
        r_mem_addr  <= r_report_addr;
        r_mem_wdata <= w_best_hash_nxt;
      end
      if (w_state_nxt == S_WR_SUM) begin
        r_mem_addr  <= r_report_addr + ADDR_W'(1);
        r_mem_wdata <= make_summary(match_count, best_nonce);
      end
      if (w_state_nxt == S_DONE) r_done <= 1'b1;
    end
  end

  scan_min_tracker #(
    .NUM_NONCES (NUM_NONCES)
  ) u_tracker (
    .clk             (clk),
    .reset           (reset),
    .i_clear         (w_accept),
    .i_vld           (r_vld),
    .i_idx           (r_idx),
    .i_word          (mem.mem_read_data),
    .i_target        (r_target),
    .o_best_hash     (best_hash),
    .o_best_hash_nxt (w_best_hash_nxt),
    .o_best_nonce    (best_nonce),
    .o_match_count   (match_count),
    .o_match_mask    (match_mask)
  );

  assign mem.mem_clk        = clk;
  assign mem.mem_we         = r_mem_we;
  assign mem.mem_addr       = r_mem_addr;
  assign mem.mem_write_data = r_mem_wdata;
  assign done               = r_done;

endmodule

// File: tb/tb_hash_result_scanner.sv
// Directed bench: memory model, write/result scoreboards, latency and address-sequence checks.
module tb_hash_result_scanner;
  import bitcoin_pkg::*;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] output_addr;
  logic [15:0] report_addr;
  logic [31:0] target;
  logic        done;
  logic [31:0] best_hash;
  logic [7:0]  best_nonce;
  logic [7:0]  match_count;
  logic [N-1:0] match_mask;

  hash_result_scanner_if #(.ADDR_W(16)) bus ();

  hash_result_scanner #(.NUM_NONCES(N), .ADDR_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .output_addr (output_addr),
    .report_addr (report_addr),
    .target      (target),
    .done        (done),
    .mem         (bus),
    .best_hash   (best_hash),
    .best_nonce  (best_nonce),
    .match_count (match_count),
    .match_mask  (match_mask)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  logic [31:0] r_rd = '0;
  assign bus.mem_read_data = r_rd;

  always @(posedge clk) begin
    r_rd <= mem[bus.mem_addr];
    if (bus.mem_we === 1'b1) mem[bus.mem_addr] = bus.mem_write_data;
  end

  typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] hash; logic [7:0] nonce; logic [7:0] count; logic [N-1:0] mask; } res_t;
  wr_t  exp_wr[$];
  res_t exp_res[$];

  int n_cmp = 0;
  int n_err = 0;
  int wr_seen = 0;
  logic done_q = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Write monitor: every mem_we cycle must match the next queued write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_seen++;
      if (exp_wr.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr %h data %h, none expected",
                 bus.mem_addr, bus.mem_write_data);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("wr_data", bus.mem_write_data, e.data);
      end
    end
  end

  // Result monitor: fires on each rising done.
  always @(negedge clk) begin
    if (done === 1'b1 && done_q === 1'b0) begin
      if (exp_res.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done with no expected result");
      end else begin
        res_t r;
        r = exp_res.pop_front();
        check("best_hash", best_hash, r.hash);
        check("best_nonce", 32'(best_nonce), 32'(r.nonce));
        check("match_count", 32'(match_count), 32'(r.count));
        check("match_mask", 32'(match_mask), 32'(r.mask));
      end
    end
    done_q = done;
  end

  task automatic fill_t1(input logic [15:0] base);
    for (int i = 0; i < N; i++) mem[16'(base + 16'(i))] = 32'h0000_1000 + 32'(i) * 32'h100;
    mem[16'(base + 16'd5)] = 32'h0000_0010;
  endtask

  task automatic run(input logic [15:0] oaddr, input logic [15:0] raddr, input logic [31:0] tgt,
                     input logic [31:0] e_hash, input logic [7:0] e_nonce, input logic [7:0] e_cnt,
                     input logic [N-1:0] e_mask, input logic [31:0] e_sum,
                     input bit disturb, input bit chk_addr);
    int n;
    int first;
    exp_wr.push_back('{raddr, e_hash});
    exp_wr.push_back('{16'(raddr + 16'd1), e_sum});
    exp_res.push_back('{e_hash, e_nonce, e_cnt, e_mask});
    @(negedge clk);
    output_addr = oaddr;
    report_addr = raddr;
    target      = tgt;
    start       = 1'b1;
    wr_seen     = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_cleared_on_start", 32'(done), 32'd0);
    check("count_cleared_on_start", 32'(match_count), 32'd0);
    if (chk_addr) check("rd_addr_0", 32'(bus.mem_addr), 32'(oaddr));
    n = 0;
    first = -1;
    while (first < 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (chk_addr && n < N) begin
        check($sformatf("rd_addr_%0d", n), 32'(bus.mem_addr), 32'(16'(oaddr + 16'(n))));
        check("rd_we_low", 32'(bus.mem_we), 32'd0);
      end
      if (disturb && n == 3) begin
        output_addr = 16'h0000;
        report_addr = 16'h0000;
        target      = 32'h0;
      end
      if (disturb && n == 5) start = 1'b1;
      if (disturb && n == 6) start = 1'b0;
      if (done === 1'b1) first = n;
    end
    // done visible in cycle N+4, i.e. N+3 edges after the start edge.
    check("done_latency_edges", 32'(first), 32'(N + 3));
    @(posedge clk);
    #1;
    check("writes_per_run", 32'(wr_seen), 32'd2);
    check("mem_hash_word", mem[raddr], e_hash);
    check("mem_summary_word", mem[16'(raddr + 16'd1)], e_sum);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    reset = 1'b1;
    start = 1'b0;
    output_addr = '0;
    report_addr = '0;
    target = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_write_data, 32'd0);
    check("rst_best_hash", best_hash, 32'hFFFF_FFFF);
    check("rst_best_nonce", 32'(best_nonce), 32'd0);
    check("rst_match_count", 32'(match_count), 32'd0);
    check("rst_match_mask", 32'(match_mask), 32'd0);
    check("mem_clk_follows_clk", 32'(bus.mem_clk), 32'(clk));
    @(negedge clk);
    reset = 1'b0;

    // Single low word among rising words.
    fill_t1(16'h0100);
    run(16'h0100, 16'h0200, 32'h0000_0800, 32'h10, 8'd5, 8'd1, 16'h0020, 32'h8001_0005, 1'b0, 1'b0);

    // Tie between indices 3 and 9.
    for (int i = 0; i < N; i++) mem[16'h0500 + i] = 32'hFFFF_0000;
    mem[16'h0503] = 32'h1;
    mem[16'h0509] = 32'h1;
    run(16'h0500, 16'h0600, 32'h2, 32'h1, 8'd3, 8'd2, 16'h0208, 32'h8002_0003, 1'b0, 1'b0);

    // All-ones digests with zero target.
    for (int i = 0; i < N; i++) mem[16'h0700 + i] = 32'hFFFF_FFFF;
    run(16'h0700, 16'h0800, 32'h0, 32'hFFFF_FFFF, 8'd0, 8'd0, 16'h0000, 32'h0000_0000, 1'b0, 1'b0);

    // Address wrap, one read per cycle; word0 equals target so does not match.
    for (int i = 0; i < N; i++) mem[16'(16'hFFF8 + 16'(i))] = 32'h100 - 32'(i);
    run(16'hFFF8, 16'h0400, 32'h100, 32'hF1, 8'd15, 8'd15, 16'hFFFE, 32'h800F_000F, 1'b0, 1'b1);

    // Mid-run start pulse and port changes are ignored.
    run(16'h0100, 16'h0210, 32'h0000_0800, 32'h10, 8'd5, 8'd1, 16'h0020, 32'h8001_0005, 1'b1, 1'b0);

    // Reset during WR_HASH: hash write lands, summary write never happens.
    mem[16'h0220] = 32'hDEAD_BEEF;
    mem[16'h0221] = 32'hDEAD_BEEF;
    exp_wr.push_back('{16'h0220, 32'h10});
    @(negedge clk);
    output_addr = 16'h0100;
    report_addr = 16'h0220;
    target = 32'h0000_0800;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (k < 100 && bus.mem_we !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    check("wr_hash_reached", 32'(k < 100), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mid_state", 32'(dut.r_state), 32'(S_IDLE));
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_best_hash", best_hash, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_hash_written", mem[16'h0220], 32'h10);
    check("rst_mid_summary_unwritten", mem[16'h0221], 32'hDEAD_BEEF);
    check("rst_mid_wr_queue_empty", 32'(exp_wr.size()), 32'd0);

    // Back-to-back runs on the same data with a looser target.
    run(16'h0100, 16'h0230, 32'h0000_0800, 32'h10, 8'd5, 8'd1, 16'h0020, 32'h8001_0005, 1'b0, 1'b0);
    check("b2b_done_high_before", 32'(done), 32'd1);
    run(16'h0100, 16'h0240, 32'h0000_2000, 32'h10, 8'd5, 8'd16, 16'hFFFF, 32'h8010_0005, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("final_wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("final_res_queue_empty", 32'(exp_res.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hash_result_scanner.md
Name: hash_result_scanner

Overview:
- Reads back the per-nonce digest words that bitcoin_hash writes to memory at output_addr.
- Checks each word against a difficulty target and tracks the minimum digest and its nonce.
- Writes a two-word summary record to report_addr, then raises done.
- Sits on the same single-port memory interface as the hasher (mem_clk/mem_we/mem_addr/mem_write_data/mem_read_data), time-shared by the top level. It runs after the hasher finishes.

Parameters:
- NUM_NONCES, 16: number of digest words to scan; legal range 1..255.
- ADDR_W, 16: memory address width.

Ports:
- clk  in  1  the only clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a scan; sampled in IDLE only.
- output_addr  in  ADDR_W  base address of digest words; word i is the digest for nonce i.
- report_addr  in  ADDR_W  base address of the 2-word summary record.
- target  in  32  a digest strictly below target is a match (unsigned).
- done  out  1  scan and summary write complete.
- mem_clk  out  1  equals clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address (registered).
- mem_write_data  out  32  write data (registered).
- mem_read_data  in  32  read data.
- best_hash  out  32  minimum digest seen.
- best_nonce  out  8  index of best_hash.
- match_count  out  8  number of digests below target.
- match_mask  out  NUM_NONCES  bit i set if digest i is below target.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, done=0, mem_we=0, mem_addr=0, mem_write_data=0, best_hash=32'hFFFFFFFF, best_nonce=0, match_count=0, match_mask=0.
- Memory timing: synchronous read. Data for the address driven in cycle c appears on mem_read_data in cycle c+1.
- States: IDLE -> READ -> DRAIN -> WR_HASH -> WR_SUM -> DONE -> IDLE.
- IDLE, start=1 at edge E0:
  - latch output_addr, report_addr and target;
  - clear best_hash to FFFFFFFF, best_nonce, match_count, match_mask and done;
  - go to READ.
- READ: in cycle k (k=1..NUM_NONCES) mem_addr=output_addr+k-1 and mem_we=0. One address per cycle, no bubbles. After the last address, go to DRAIN.
- Compare pipeline: a 1-cycle valid/index delay register marks returning data. Word i is compared at the end of cycle i+2:
  - if word < best_hash: best_hash<=word, best_nonce<=i (strict, so ties keep the lower index);
  - if word < target: set match_mask[i] and increment match_count.
- DRAIN: one cycle to absorb the last returning word. Then go to WR_HASH.
- WR_HASH: mem_we=1, mem_addr=report_addr, mem_write_data=best_hash, including the final compare.
- WR_SUM: mem_we=1, mem_addr=report_addr+1, mem_write_data={found,7'b0,match_count,8'b0,best_nonce}, where found=(match_count!=0).
- DONE: mem_we=0 and done<=1; return to IDLE.
- done stays high until the next accepted start or reset.
- Latency: done is first visible in cycle NUM_NONCES+4 after the start edge.
- Address arithmetic wraps modulo 2^ADDR_W.
- A target of 0 means no digest can match.
- All-FFFFFFFF digests give best_nonce=0 and best_hash=FFFFFFFF.
- start outside IDLE is ignored. Port changes after the start edge have no effect.
- reset in any state returns to IDLE with reset values next edge. mem_we deasserts on that same edge, so no partial summary write completes afterwards.
- mem_we is 0 in every state except WR_HASH and WR_SUM.

Decomposition:
- Shared package bitcoin_pkg:
  - scanner state enum;
  - NUM_NONCES default;
  - summary field positions: FOUND_BIT=31, COUNT_LSB=16, NONCE_LSB=0;
  - SUMMARY_WORDS=2.
- One sub-module, scan_min_tracker: takes valid/index/word/target and holds the best_hash/best_nonce/match_count/match_mask registers, with a clear input.
- The FSM and address counter stay in hash_result_scanner.

Test Plan:
- Memory output_addr=0x0100 holding 16 words 0x0000_1000+i*0x100 with word 5 set to 0x0000_0010, target=0x0000_0800 -> best_hash=0x10, best_nonce=5, match_count=1, mem[report_addr]=0x10, mem[report_addr+1]=0x8001_0005, done first visible in cycle 20 after the start edge.
- Words 3 and 9 both 0x0000_0001, others 0xFFFF_0000, target=0x0000_0002 -> best_nonce=3, match_count=2, match_mask=0x0208, summary=0x8002_0003.
- All words 0xFFFF_FFFF, target=0 -> best_hash=FFFF_FFFF, best_nonce=0, found=0, summary=0x0000_0000.
- Address sequence check: one read per cycle, output_addr=0xFFF8 with NUM_NONCES=16 -> mem_addr sequence FFF8..FFFF,0000..0007; exactly 2 writes observed.
- start pulsed again during READ -> ignored, results unchanged. Then reset asserted during WR_HASH -> next cycle mem_we=0, state IDLE, done=0, best_hash=FFFF_FFFF, and mem[report_addr+1] is unwritten.
- Back-to-back runs: second start with different target=0x0000_2000 on the same data -> counters cleared, done drops on start, new match_count=16.
